hazard_controller: RTL

Hazard and sequencing controller for the decode stage. It keeps a shadow of the destination registers in flight in EXE, MEM and WB, and from that shadow drives the select lines of the two decode-stage operand forwarding muxes. It also detects load-use hazards and stalls fetch/decode for them. It runs the syscall drain sequence: freeze, drain the pipeline, pulse SYS, then release.

---
 rtl/hazard_controller.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - decode-stage forwarding, load-use stall and syscall drain control
module hazard_controller (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IDValid,
    input  logic [4:0] Rs,
    input  logic [4:0] Rt,
    input  logic       UsesRs,
    input  logic       UsesRt,
    input  logic [4:0] ID_WriteReg,
    input  logic       ID_RegWrite,
    input  logic       ID_MemRead,
    input  logic       ID_Syscall,
    output logic [1:0] SelectA,
    output logic [1:0] SelectB,
    output logic       Stall,
    output logic       Bubble,
    output logic       SYS
);

    // Gray-ordered encoding: every legal transition flips one bit, so the
    // SYSC decode cannot glitch while the state register changes.
    typedef enum logic [1:0] {
        RUN     = 2'b00,
        DRAIN   = 2'b01,
        SYSC    = 2'b11,
        RELEASE = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;

    // Shadow slots: valid, writes-register, destination, is-load
    logic       exe_v, exe_w, exe_l;
    logic [4:0] exe_r;
    logic       mem_v, mem_w, mem_l;
    logic [4:0] mem_r;
    logic       wb_v, wb_w, wb_l;
    logic [4:0] wb_r;

    logic       lu_a;
    logic       lu_b;
    logic       load_use;

    // Youngest matching producer wins; a load still in EXE cannot forward yet
    function automatic logic [1:0] fwd_sel(
        input logic       used,
        input logic [4:0] src,
        input logic       ev,
        input logic       ew,
        input logic [4:0] er,
        input logic       el,
        input logic       mv,
        input logic       mw,
        input logic [4:0] mr,
        input logic       wv,
        input logic       ww,
        input logic [4:0] wr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && (src != 5'd0)) begin
            if (ev && ew && (er == src)) begin
                sel = el ? 2'b00 : 2'b01;
            end else if (mv && mw && (mr == src)) begin
                sel = 2'b10;
            end else if (wv && ww && (wr == src)) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    // Shift the shadow pipeline; a bubble or invalid decode inserts an empty slot
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            exe_v <= 1'b0; exe_w <= 1'b0; exe_r <= 5'd0; exe_l <= 1'b0;
            mem_v <= 1'b0; mem_w <= 1'b0; mem_r <= 5'd0; mem_l <= 1'b0;
            wb_v  <= 1'b0; wb_w  <= 1'b0; wb_r  <= 5'd0; wb_l  <= 1'b0;
        end else begin
            wb_v  <= mem_v; wb_w  <= mem_w; wb_r  <= mem_r; wb_l  <= mem_l;
            mem_v <= exe_v; mem_w <= exe_w; mem_r <= exe_r; mem_l <= exe_l;
            if (IDValid && !Bubble) begin
                exe_v <= 1'b1;
                exe_w <= ID_RegWrite && (ID_WriteReg != 5'd0);
                exe_r <= ID_WriteReg;
                exe_l <= ID_MemRead;
            end else begin
                exe_v <= 1'b0;
                exe_w <= 1'b0;
                exe_r <= 5'd0;
                exe_l <= 1'b0;
            end
        end
    end

    // Operand mux selects and load-use detection from the shadow slots
    always_comb begin
        SelectA  = fwd_sel(UsesRs, Rs, exe_v, exe_w, exe_r, exe_l,
                           mem_v, mem_w, mem_r, wb_v, wb_w, wb_r);
        SelectB  = fwd_sel(UsesRt, Rt, exe_v, exe_w, exe_r, exe_l,
                           mem_v, mem_w, mem_r, wb_v, wb_w, wb_r);
        lu_a     = UsesRs && (Rs != 5'd0) && exe_v && exe_w && exe_l && (exe_r == Rs);
        lu_b     = UsesRt && (Rt != 5'd0) && exe_v && exe_w && exe_l && (exe_r == Rt);
        load_use = IDValid && (lu_a || lu_b);
    end

    // Syscall sequencer state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Syscall sequencer next-state: freeze, drain, pulse, release
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (IDValid && ID_Syscall) state_d = DRAIN;
            DRAIN:   if (!exe_v && !mem_v && !wb_v) state_d = SYSC;
            SYSC:    state_d = RELEASE;
            RELEASE: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Syscall sequencer outputs; load-use only matters while running normally
    always_comb begin
        Stall  = 1'b0;
        Bubble = 1'b0;
        SYS    = 1'b0;
        case (state_q)
            RUN: begin
                Stall  = (IDValid && ID_Syscall) || load_use;
                Bubble = (IDValid && ID_Syscall) || load_use;
            end
            DRAIN: begin
                Stall  = 1'b1;
                Bubble = 1'b1;
            end
            SYSC: begin
                Stall  = 1'b1;
                Bubble = 1'b1;
                SYS    = 1'b1;
            end
            default: begin
                Stall  = 1'b0;
                Bubble = 1'b0;
            end
        endcase
    end

endmodule
